// File: rtl/bus_cycle_controller_if.sv
// 68030 asynchronous bus-cycle signals shared by the CPU side (master)
// and the cycle-termination engine (slave).
interface bus_cycle_controller_if #(
    parameter int NCH = 4
);
    logic           AS_n;
    logic           DS_n;
    logic [2:0]     FC;
    logic [NCH-1:0] CS_n;
    logic [NCH-1:0] EXT_ACK_n;
    logic           DSACK0_n;
    logic           DSACK1_n;
    logic           BERR_n;
    logic           BOOT;
    logic           BUSY;

    modport master (
        output AS_n, DS_n, FC, CS_n, EXT_ACK_n,
        input  DSACK0_n, DSACK1_n, BERR_n, BOOT, BUSY
    );

    modport slave (
        input  AS_n, DS_n, FC, CS_n, EXT_ACK_n,
        output DSACK0_n, DSACK1_n, BERR_n, BOOT, BUSY
    );
endinterface

// File: rtl/bus_cycle_controller.sv
// 68030 bus-cycle termination: per-channel wait states or external ack, DSACK by port width,
// BOOT overlay from a completed-cycle count. Optional bus timeout/BERR: BUS_CYCLE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no cycle latched; waiting for AS_n low with a chip select
// WAIT  | channel latched; counting wait states or waiting for EXT_ACK_n
// ACK   | DSACK driven for the latched width until AS_n rises
// BERR  | bus error driven until AS_n rises
module bus_cycle_controller #(
    parameter int                  NCH         = 4,
    parameter int                  WS_W        = 4,
    parameter logic [NCH*WS_W-1:0] WAIT_STATES = '0,
    parameter logic [NCH*2-1:0]    PORT_SIZE   = '0,
    parameter logic [NCH-1:0]      EXT_MASK    = '0,
    parameter int                  TO_W        = 8,
    parameter int                  TIMEOUT     = 255,
    parameter int                  BOOT_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    bus_cycle_controller_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel, hit_idx;
    logic [1:0]       size, hit_size;
    logic             ext, hit_ext, hit;
    logic [WS_W-1:0]  cnt, hit_ws;
    logic [7:0]       boot_cnt;
    logic             dsack0_n, dsack1_n, boot;
    logic             cycle_start, ext_ack, retire;
    logic             unused_ds;

    assign unused_ds = bus.DS_n;

    // returns {DSACK1_n, DSACK0_n}; reserved width 11 falls back to 8-bit
    function automatic logic [1:0] dsack_n_for(input logic [1:0] ps);
        case (ps)
            2'b01:   return 2'b01;
            2'b10:   return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_size = '0;
        hit_ext  = 1'b0;
        hit_ws   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!bus.CS_n[i]) begin
                hit      = 1'b1;
                hit_idx  = SEL_W'(i);
                hit_size = PORT_SIZE[i*2 +: 2];
                hit_ext  = EXT_MASK[i];
                hit_ws   = WAIT_STATES[i*WS_W +: WS_W];
            end
        end
    end

    assign cycle_start = !bus.AS_n && (bus.FC != 3'b111) && hit;
    assign ext_ack     = !bus.EXT_ACK_n[sel];
    assign retire      = bus.AS_n && (state == ACK || state == BERR);

`ifdef BUS_CYCLE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            berr_n, to_hit;

    // fires on the edge that would make the count reach TIMEOUT
    assign to_hit = !bus.AS_n && (state == IDLE || state == WAIT) &&
                    (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            to_cnt <= '0;
        else if (bus.AS_n)
            to_cnt <= '0;
        else if (state == IDLE || state == WAIT)
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign bus.BERR_n = berr_n;
`else
    assign bus.BERR_n = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            sel      <= '0;
            size     <= '0;
            ext      <= 1'b0;
            cnt      <= '0;
            dsack0_n <= 1'b1;
            dsack1_n <= 1'b1;
`ifdef BUS_CYCLE_TIMEOUT_EN
            berr_n   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cycle_start) begin
                        sel  <= hit_idx;
                        size <= hit_size;
                        ext  <= hit_ext;
                        cnt  <= hit_ws;
                        if (!hit_ext && hit_ws == '0) begin
                            state                  <= ACK;
                            {dsack1_n, dsack0_n}   <= dsack_n_for(hit_size);
                        end
`ifdef BUS_CYCLE_TIMEOUT_EN
                        else if (to_hit) begin
                            state  <= BERR;
                            berr_n <= 1'b0;
                        end
`endif
                        else
                            state <= WAIT;
                    end
`ifdef BUS_CYCLE_TIMEOUT_EN
                    else if (to_hit) begin
                        state  <= BERR;
                        berr_n <= 1'b0;
                    end
`endif
                end
                WAIT: begin
                    if (bus.AS_n)
                        state <= IDLE;
                    else if (ext ? ext_ack : (cnt == WS_W'(1))) begin
                        state                <= ACK;
                        {dsack1_n, dsack0_n} <= dsack_n_for(size);
                    end else begin
                        cnt <= cnt - WS_W'(1);
`ifdef BUS_CYCLE_TIMEOUT_EN
                        if (to_hit) begin
                            state  <= BERR;
                            berr_n <= 1'b0;
                        end
`endif
                    end
                end
                ACK: begin
                    if (bus.AS_n) begin
                        state    <= IDLE;
                        dsack0_n <= 1'b1;
                        dsack1_n <= 1'b1;
                    end
                end
                BERR: begin
`ifdef BUS_CYCLE_TIMEOUT_EN
                    if (bus.AS_n) begin
                        state  <= IDLE;
                        berr_n <= 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BOOT is sticky, so the counter can simply stop once it fires
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            boot_cnt <= '0;
            boot     <= 1'b0;
        end else if (retire && !boot) begin
            boot_cnt <= boot_cnt + 8'd1;
            if (boot_cnt + 8'd1 >= 8'(BOOT_CYCLES))
                boot <= 1'b1;
        end
    end

    assign bus.DSACK0_n = dsack0_n;
    assign bus.DSACK1_n = dsack1_n;
    assign bus.BOOT     = boot;
    assign bus.BUSY     = (state != IDLE);
endmodule
